half_subtractor: RTL and testbench

- Lane-parallel half subtractor. For each bit lane it computes difference d = a XOR b and borrow bor = (NOT a) AND b.
- Outputs come in two forms: a zero-latency combinational form, and a registered form with a valid flag.
- A saturating borrow-event counter supports datapath monitoring.
- Leaf arithmetic cell used by ripple/borrow-chain subtractors and comparison logic.

---
 rtl/half_subtractor.sv | 54 +++++
 tb/tb_half_subtractor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - lane-parallel half subtractor with registered path and borrow counter
module half_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] bor,
  output logic [WIDTH-1:0] d_q,
  output logic [WIDTH-1:0] bor_q,
  output logic             out_valid,
  output logic             bor_any_q,
  output logic [CNT_W-1:0] bor_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic bor_any;

  // Lanes never interact: no borrow ripples from one lane into the next.
  assign d       = a ^ b;
  assign bor     = ~a & b;
  assign bor_any = |bor;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q       <= '0;
      bor_q     <= '0;
      out_valid <= 1'b0;
      bor_any_q <= 1'b0;
      bor_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d_q       <= d;
        bor_q     <= bor;
        bor_any_q <= bor_any;
      end
      // Clear wins over a same-cycle borrow event, which is dropped.
      if (cnt_clr) begin
        bor_cnt <= '0;
      end else if (in_valid && bor_any && (bor_cnt != CNT_MAX)) begin
        bor_cnt <= bor_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor.sv
// tb/tb_half_subtractor.sv - table-driven scoreboard bench for half_subtractor
module tb_half_subtractor;

  typedef struct {
    logic a;
    logic b;
    logic d;
    logic bor;
  } vec_t;

  typedef struct {
    logic d;
    logic bor;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cnt_clr;
  logic       cnt_clr4;
  logic       a1, b1, in_valid1;
  logic       d1, bor1, dq1, borq1, ov1, any1;
  logic [1:0] cnt1;
  logic [3:0] a4, b4, d4, bor4, dq4, borq4;
  logic       in_valid4, ov4, any4;
  logic [15:0] cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t tt[4];
  exp_t sb_q[$];
  exp_t last_exp;
  logic m_ov;
  logic [1:0] m_cnt;

  always #5 clk = ~clk;

  half_subtractor #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid1), .cnt_clr(cnt_clr),
    .d(d1), .bor(bor1), .d_q(dq1), .bor_q(borq1), .out_valid(ov1),
    .bor_any_q(any1), .bor_cnt(cnt1)
  );

  half_subtractor #(.WIDTH(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(in_valid4), .cnt_clr(cnt_clr4),
    .d(d4), .bor(bor4), .d_q(dq4), .bor_q(borq4), .out_valid(ov4),
    .bor_any_q(any4), .bor_cnt(cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; the single-lane reference model advances alongside.
  task automatic tick();
    exp_t e;
    if (!rst_n) begin
      m_ov  = 1'b0;
      m_cnt = 2'd0;
      sb_q.delete();
      last_exp = '{d: 1'b0, bor: 1'b0};
    end else begin
      m_ov = in_valid1;
      if (in_valid1) begin
        e.d   = a1 ^ b1;
        e.bor = ~a1 & b1;
        sb_q.push_back(e);
      end
      if (cnt_clr) m_cnt = 2'd0;
      else if (in_valid1 && (~a1 & b1) && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    end
    @(posedge clk);
    #1;
    chk("out_valid", ov1, m_ov);
    chk("bor_cnt", cnt1, m_cnt);
    if (ov1 === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        last_exp = sb_q.pop_front();
      end
    end
    chk("d_q", dq1, last_exp.d);
    chk("bor_q", borq1, last_exp.bor);
    chk("bor_any_q", any1, last_exp.bor);
  endtask

  initial begin
    int sat_exp[5];
    tt[0] = '{a: 1'b0, b: 1'b0, d: 1'b0, bor: 1'b0};
    tt[1] = '{a: 1'b0, b: 1'b1, d: 1'b1, bor: 1'b1};
    tt[2] = '{a: 1'b1, b: 1'b0, d: 1'b1, bor: 1'b0};
    tt[3] = '{a: 1'b1, b: 1'b1, d: 1'b0, bor: 1'b0};
    sat_exp = '{1, 2, 3, 3, 3};
    last_exp = '{d: 1'b0, bor: 1'b0};
    m_ov = 1'b0;
    m_cnt = 2'd0;

    rst_n = 1'b0; cnt_clr = 1'b0; cnt_clr4 = 1'b0;
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0;

    // Combinational truth table, no edges involved in the result
    for (int i = 0; i < 4; i++) begin
      a1 = tt[i].a; b1 = tt[i].b;
      #5;
      chk("tt_d", d1, tt[i].d);
      chk("tt_bor", bor1, tt[i].bor);
      #5;
    end

    // Reset beats in_valid; combinational path unaffected
    a1 = 1'b0; b1 = 1'b1; in_valid1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_d", d1, 1'b1);
      chk("rst_bor", bor1, 1'b1);
    end

    // Back-to-back valid pipeline
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = tt[i].a; b1 = tt[i].b; in_valid1 = 1'b1;
      tick();
      chk("pipe_ov", ov1, 1'b1);
      chk("pipe_dq", dq1, tt[i].d);
    end
    chk("pipe_cnt", cnt1, 2'd1);

    // Load a borrowing value, then hold with in_valid low
    a1 = 1'b0; b1 = 1'b1; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = tt[i].a; b1 = tt[i].b;
      tick();
      chk("hold_d", d1, tt[i].d);
      chk("hold_bor", bor1, tt[i].bor);
      chk("hold_dq", dq1, 1'b1);
      chk("hold_cnt", cnt1, 2'd2);
    end

    // Saturation then clear-over-increment
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    a1 = 1'b0; b1 = 1'b1; in_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_cnt", cnt1, sat_exp[i]);
    end
    cnt_clr = 1'b1;
    tick();
    chk("clr_cnt", cnt1, 2'd0);
    cnt_clr = 1'b0;
    tick();
    chk("post_clr_cnt", cnt1, 2'd1);

    // Reset mid-stream drops the in-flight valid
    a1 = 1'b1; b1 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid1 = 1'b0;
    tick();
    chk("midrst_ov", ov1, 1'b0);
    chk("midrst_cnt", cnt1, 2'd0);

    // Multi-lane
    chk("ml_cnt0", cnt4, 16'd0);
    a4 = 4'b1010; b4 = 4'b0110; in_valid4 = 1'b1;
    #1;
    chk("ml_d", d4, 4'b1100);
    chk("ml_bor", bor4, 4'b0100);
    tick();
    chk("ml_ov", ov4, 1'b1);
    chk("ml_dq", dq4, 4'b1100);
    chk("ml_borq", borq4, 4'b0100);
    chk("ml_any", any4, 1'b1);
    chk("ml_cnt1", cnt4, 16'd1);
    a4 = 4'b1111; b4 = 4'b0000;
    tick();
    chk("ml_any0", any4, 1'b0);
    chk("ml_dq2", dq4, 4'b1111);
    chk("ml_cnt2", cnt4, 16'd1);
    in_valid4 = 1'b0;
    tick();
    chk("ml_ov0", ov4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
